// File: rtl/seven_seg_scan_decoder.sv
// Purpose: recovers per-digit 4-bit values from a multiplexed seven-segment bus with a per-digit stability filter.
// Latency: outputs update on the edge that takes the STABLE_CNT-th identical sample; visible the following cycle.
// Backpressure: none; every sample strobe is consumed on its edge.
module seven_seg_scan_decoder #(
  parameter int NUM_DIGITS = 4,
  parameter int STABLE_CNT = 3
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [6:0]              seg,
  input  logic [NUM_DIGITS-1:0]   dig_sel,
  input  logic                    sample,
  output logic [4*NUM_DIGITS-1:0] digit_val,
  output logic [NUM_DIGITS-1:0]   digit_vld,
  output logic [NUM_DIGITS-1:0]   digit_err,
  output logic                    upd,
  output logic                    sel_err
);

  localparam int CW = $clog2(STABLE_CNT + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CNT);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  typedef enum logic [1:0] {
    K_NUM     = 2'd0,
    K_BLANK   = 2'd1,
    K_ILLEGAL = 2'd2
  } kind_e;

  // Segment pattern {g,f,e,d,c,b,a} to {kind, value}; blank and illegal carry value 0.
  function automatic logic [5:0] decode(input logic [6:0] p);
    logic [5:0] r;
    case (p)
      7'h3F:   r = {K_NUM, 4'd0};
      7'h06:   r = {K_NUM, 4'd1};
      7'h5B:   r = {K_NUM, 4'd2};
      7'h4F:   r = {K_NUM, 4'd3};
      7'h66:   r = {K_NUM, 4'd4};
      7'h6D:   r = {K_NUM, 4'd5};
      7'h7D:   r = {K_NUM, 4'd6};
      7'h07:   r = {K_NUM, 4'd7};
      7'h7F:   r = {K_NUM, 4'd8};
      7'h6F:   r = {K_NUM, 4'd9};
      7'h00:   r = {K_BLANK, 4'd0};
      default: r = {K_ILLEGAL, 4'd0};
    endcase
    return r;
  endfunction

  // Per-digit filter state, packed: cand of digit i at [7i+6:7i], cnt at [CW*i+CW-1:CW*i].
  logic [7*NUM_DIGITS-1:0]  cand, cand_nxt;
  logic [CW*NUM_DIGITS-1:0] cnt, cnt_nxt;
  logic [4*NUM_DIGITS-1:0]  val_nxt;
  logic [NUM_DIGITS-1:0]    vld_nxt, err_nxt;
  logic                     upd_nxt;
  logic [3:0]               sel_ones;
  logic                     sel_onehot;
  logic [5:0]               seg_dec;
  kind_e                    seg_kind;

  assign seg_dec    = decode(seg);
  assign seg_kind   = kind_e'(seg_dec[5:4]);
  assign sel_onehot = (sel_ones == 4'd1);

  // Population count of the digit select, used to reject zero or multi-hot selects.
  always_comb begin
    sel_ones = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      sel_ones = sel_ones + {3'b000, dig_sel[i]};
    end
  end

  // Advance the selected digit's filter and build its commit result; other digits hold.
  always_comb begin
    logic            commit;
    logic [CW-1:0]   cnt_cur;
    cand_nxt = cand;
    cnt_nxt  = cnt;
    val_nxt  = digit_val;
    vld_nxt  = digit_vld;
    err_nxt  = digit_err;
    upd_nxt  = 1'b0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      commit  = 1'b0;
      cnt_cur = cnt[CW*i +: CW];
      if (sample && sel_onehot && dig_sel[i]) begin
        if (seg == cand[7*i +: 7]) begin
          // A saturated counter means this pattern already committed; do not recommit.
          if (cnt_cur != CNT_MAX) begin
            cnt_nxt[CW*i +: CW] = cnt_cur + CNT_ONE;
            commit = ((cnt_cur + CNT_ONE) == CNT_MAX);
          end
        end else begin
          cand_nxt[7*i +: 7]  = seg;
          cnt_nxt[CW*i +: CW] = CNT_ONE;
          commit = (CNT_ONE == CNT_MAX);
        end
        if (commit) begin
          case (seg_kind)
            K_NUM: begin
              val_nxt[4*i +: 4] = seg_dec[3:0];
              vld_nxt[i]        = 1'b1;
              err_nxt[i]        = 1'b0;
            end
            K_BLANK: begin
              vld_nxt[i] = 1'b0;
              err_nxt[i] = 1'b0;
            end
            default: begin
              vld_nxt[i] = 1'b0;
              err_nxt[i] = 1'b1;
            end
          endcase
          upd_nxt = upd_nxt |
                    ({val_nxt[4*i +: 4], vld_nxt[i], err_nxt[i]} !=
                     {digit_val[4*i +: 4], digit_vld[i], digit_err[i]});
        end
      end
    end
  end

  // Register filter state, committed outputs and the single-cycle pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cand      <= '0;
      cnt       <= '0;
      digit_val <= '0;
      digit_vld <= '0;
      digit_err <= '0;
      upd       <= 1'b0;
      sel_err   <= 1'b0;
    end else begin
      cand      <= cand_nxt;
      cnt       <= cnt_nxt;
      digit_val <= val_nxt;
      digit_vld <= vld_nxt;
      digit_err <= err_nxt;
      upd       <= upd_nxt;
      sel_err   <= sample && !sel_onehot;
    end
  end

endmodule

// File: tb/tb_seven_seg_scan_decoder.sv
// Purpose: directed bench for seven_seg_scan_decoder with an expected-result queue per sample strobe.
// Latency: each strobe is driven on a falling edge and its result checked on the next falling edge.
// Backpressure: none; the bench paces itself on the clock.
module tb_seven_seg_scan_decoder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [6:0]  seg = 7'h00;
  logic [3:0]  dig_sel = 4'h0;
  logic        sample = 1'b0;
  logic        sample1 = 1'b0;

  logic [15:0] digit_val, digit_val1;
  logic [3:0]  digit_vld, digit_vld1;
  logic [3:0]  digit_err, digit_err1;
  logic        upd, upd1;
  logic        sel_err, sel_err1;

  seven_seg_scan_decoder #(.NUM_DIGITS(4), .STABLE_CNT(3)) dut (
    .clk(clk), .rst_n(rst_n), .seg(seg), .dig_sel(dig_sel), .sample(sample),
    .digit_val(digit_val), .digit_vld(digit_vld), .digit_err(digit_err),
    .upd(upd), .sel_err(sel_err)
  );

  seven_seg_scan_decoder #(.NUM_DIGITS(4), .STABLE_CNT(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .seg(seg), .dig_sel(dig_sel), .sample(sample1),
    .digit_val(digit_val1), .digit_vld(digit_vld1), .digit_err(digit_err1),
    .upd(upd1), .sel_err(sel_err1)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0] val;
    logic [3:0]  vld;
    logic [3:0]  err;
    logic        upd;
    logic        sel_err;
  } exp_t;

  exp_t        sb[$];
  int          n_assert = 0;
  int          n_fail = 0;
  logic [15:0] ev = 16'h0000;
  logic [3:0]  evld = 4'h0;
  logic [3:0]  eerr = 4'h0;
  logic [6:0]  pats[4] = '{7'h06, 7'h4F, 7'h6D, 7'h7F};
  logic [3:0]  codes[4] = '{4'd1, 4'd3, 4'd5, 4'd8};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_assert++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // Pop the oldest expectation and compare it with the main DUT outputs.
  task automatic check_out(input string tag);
    exp_t e;
    e = sb.pop_front();
    chk({tag, ".val"},     32'(digit_val), 32'(e.val));
    chk({tag, ".vld"},     32'(digit_vld), 32'(e.vld));
    chk({tag, ".err"},     32'(digit_err), 32'(e.err));
    chk({tag, ".upd"},     32'(upd),       32'(e.upd));
    chk({tag, ".sel_err"}, 32'(sel_err),   32'(e.sel_err));
  endtask

  // One sample strobe on the main DUT; called on a falling edge.
  task automatic step(input string tag, input logic [6:0] s, input logic [3:0] sel,
                      input logic u, input logic se);
    sb.push_back({ev, evld, eerr, u, se});
    seg = s;
    dig_sel = sel;
    sample = 1'b1;
    @(negedge clk);
    sample = 1'b0;
    check_out(tag);
  endtask

  task automatic idle(input string tag);
    sb.push_back({ev, evld, eerr, 1'b0, 1'b0});
    @(negedge clk);
    check_out(tag);
  endtask

  initial begin
    // Reset state
    #12;
    sb.push_back({16'h0000, 4'h0, 4'h0, 1'b0, 1'b0});
    check_out("reset");
    chk("reset1.val", 32'(digit_val1), 32'h0);
    chk("reset1.upd", 32'(upd1), 32'h0);
    rst_n = 1'b1;
    @(negedge clk);

    // Three samples of 0x5B commit 2 on digit 0; a fourth does not recommit
    step("d0_5b_1", 7'h5B, 4'b0001, 1'b0, 1'b0);
    step("d0_5b_2", 7'h5B, 4'b0001, 1'b0, 1'b0);
    ev = 16'h0002; evld = 4'b0001;
    step("d0_5b_3", 7'h5B, 4'b0001, 1'b1, 1'b0);
    step("d0_5b_4", 7'h5B, 4'b0001, 1'b0, 1'b0);
    idle("idle_1");

    // Round-robin scan, three passes; each digit commits on its third sample
    for (int scan = 0; scan < 3; scan++) begin
      for (int d = 0; d < 4; d++) begin
        if (scan == 2) begin
          ev[4*d +: 4] = codes[d];
          evld[d] = 1'b1;
        end
        step($sformatf("scan%0d_d%0d", scan, d), pats[d], 4'(1 << d), scan == 2, 1'b0);
      end
    end
    chk("scan_final.val", 32'(digit_val), 32'h8531);

    // Move digit 0 to 7, then 3F,3F,06,06,06: no commit of 0, value 1 on the fifth
    step("d0_07_1", 7'h07, 4'b0001, 1'b0, 1'b0);
    step("d0_07_2", 7'h07, 4'b0001, 1'b0, 1'b0);
    ev[3:0] = 4'd7;
    step("d0_07_3", 7'h07, 4'b0001, 1'b1, 1'b0);
    step("d0_3f_1", 7'h3F, 4'b0001, 1'b0, 1'b0);
    step("d0_3f_2", 7'h3F, 4'b0001, 1'b0, 1'b0);
    step("d0_06_1", 7'h06, 4'b0001, 1'b0, 1'b0);
    step("d0_06_2", 7'h06, 4'b0001, 1'b0, 1'b0);
    ev[3:0] = 4'd1;
    step("d0_06_3", 7'h06, 4'b0001, 1'b1, 1'b0);

    // Digit 1: commit 7, then illegal 0x49, then blank
    step("d1_07_1", 7'h07, 4'b0010, 1'b0, 1'b0);
    step("d1_07_2", 7'h07, 4'b0010, 1'b0, 1'b0);
    ev[7:4] = 4'd7;
    step("d1_07_3", 7'h07, 4'b0010, 1'b1, 1'b0);
    step("d1_49_1", 7'h49, 4'b0010, 1'b0, 1'b0);
    step("d1_49_2", 7'h49, 4'b0010, 1'b0, 1'b0);
    evld[1] = 1'b0; eerr[1] = 1'b1;
    step("d1_49_3", 7'h49, 4'b0010, 1'b1, 1'b0);
    step("d1_00_1", 7'h00, 4'b0010, 1'b0, 1'b0);
    step("d1_00_2", 7'h00, 4'b0010, 1'b0, 1'b0);
    eerr[1] = 1'b0;
    step("d1_00_3", 7'h00, 4'b0010, 1'b1, 1'b0);

    // Bad selects pulse sel_err and leave digit 0's filter alone
    step("sel_none", 7'h3F, 4'b0000, 1'b0, 1'b1);
    step("sel_multi", 7'h3F, 4'b0011, 1'b0, 1'b1);
    idle("idle_sel");
    step("d0_3f_a", 7'h3F, 4'b0001, 1'b0, 1'b0);
    step("d0_3f_b", 7'h3F, 4'b0001, 1'b0, 1'b0);
    ev[3:0] = 4'd0;
    step("d0_3f_c", 7'h3F, 4'b0001, 1'b1, 1'b0);

    // Single-sample filter build: one 0x6F on digit 2 commits 9
    seg = 7'h6F; dig_sel = 4'b0100; sample1 = 1'b1;
    @(negedge clk);
    sample1 = 1'b0;
    chk("sc1.val", 32'(digit_val1), 32'h0900);
    chk("sc1.vld", 32'(digit_vld1), 32'h4);
    chk("sc1.err", 32'(digit_err1), 32'h0);
    chk("sc1.upd", 32'(upd1), 32'h1);
    idle("idle_sc1");
    chk("sc1.upd_drop", 32'(upd1), 32'h0);

    // Reset in the middle of a filter run discards the partial count
    step("d0_66_1", 7'h66, 4'b0001, 1'b0, 1'b0);
    step("d0_66_2", 7'h66, 4'b0001, 1'b0, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    ev = 16'h0000; evld = 4'h0; eerr = 4'h0;
    sb.push_back({ev, evld, eerr, 1'b0, 1'b0});
    check_out("async_rst");
    chk("async_rst1.val", 32'(digit_val1), 32'h0);
    @(negedge clk);
    #2;
    rst_n = 1'b1;
    @(negedge clk);
    step("post_rst_66_1", 7'h66, 4'b0001, 1'b0, 1'b0);
    step("post_rst_66_2", 7'h66, 4'b0001, 1'b0, 1'b0);
    ev[3:0] = 4'd4; evld = 4'b0001;
    step("post_rst_66_3", 7'h66, 4'b0001, 1'b1, 1'b0);
    idle("idle_end");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/seven_seg_scan_decoder.md
Name: seven_seg_scan_decoder

Overview:
- Receive side of the team's seven-segment interface: samples a multiplexed segment bus plus a one-hot digit select and recovers the 4-bit value shown on each digit.
- Each digit has its own stability filter, so a value commits only after STABLE_CNT consecutive identical samples.
- Used as a display monitor or scoreboard front end behind the binary-to-segment controller, and for readback of scanned displays.

Parameters:
- NUM_DIGITS, 4: number of multiplexed digits; legal range 1..8.
- STABLE_CNT, 3: consecutive identical samples required to commit a digit; legal range 1..15.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- seg  input  7  segment pattern {g,f,e,d,c,b,a}, active-high (1 = lit).
- dig_sel  input  NUM_DIGITS  one-hot active-high digit enable; bit i selects digit i.
- sample  input  1  single-cycle strobe that samples seg/dig_sel on this edge.
- digit_val  output  4*NUM_DIGITS  committed value per digit; digit i occupies [4i+3:4i].
- digit_vld  output  NUM_DIGITS  digit i holds a committed legal numeral.
- digit_err  output  NUM_DIGITS  last commit of digit i was an illegal pattern.
- upd  output  1  one-cycle pulse: some digit's val/vld/err changed.
- sel_err  output  1  one-cycle pulse: sample taken with dig_sel not exactly one-hot.

Behaviour:
- Reset (async assert, sync release): digit_val, digit_vld, digit_err, upd, sel_err, every candidate pattern and every counter go to 0.
- Decode table (seg hex -> value): 3F->0, 06->1, 5B->2, 4F->3, 66->4, 6D->5, 7D->6, 07->7, 7F->8, 6F->9.
- 00 is "blank" (legal, no value). Any other pattern is illegal.
- Per digit i, state is cand[i] (7b) and cnt[i] (width clog2(STABLE_CNT+1), saturating at STABLE_CNT).
- Sample with one-hot dig_sel selecting digit i:
  - If seg == cand[i] and cnt[i] < STABLE_CNT: cnt[i]++.
  - If seg != cand[i]: cand[i] <= seg, cnt[i] <= 1.
- Commit fires on the edge where cnt[i] becomes STABLE_CNT. This includes the first sample when STABLE_CNT = 1. A saturated digit re-sampled with the same pattern does not recommit.
- Commit results:
  - Legal numeral: digit_val[i] <= code, vld = 1, err = 0.
  - Blank: vld = 0, err = 0, val holds.
  - Illegal: vld = 0, err = 1, val holds.
- Latency: outputs update on the commit edge, i.e. visible in the cycle after the STABLE_CNT-th sample strobe.
- upd is registered and asserts on the same edge as the commit, only if the (val, vld, err) triple of that digit differs from its previous value. It deasserts on the next edge unless another changing commit occurs.
- sample = 1 with dig_sel == 0 or more than one bit set: no per-digit state changes; sel_err pulses one cycle.
- sample = 0: all state holds; seg and dig_sel are don't-care.
- Digits are independent. Sampling digit j never touches cand or cnt of digit i != j, so interleaved scanning is the normal case.
- Reset asserted mid-filter discards partial counts; after release, STABLE_CNT fresh samples are needed per digit.

Test Plan:
- Reset, then 3 samples of seg=0x5B with dig_sel=0001 -> after the 3rd: digit_val[3:0]=2, digit_vld=0001, upd pulses once. A 4th identical sample -> no upd.
- Round-robin digits 0..3 with 0x06, 0x4F, 0x6D, 0x7F, 3 full scans -> digit_val=16'h8531, digit_vld=1111. Exactly 4 upd pulses, one per digit on its third sample.
- Digit 0 fed 0x3F, 0x3F, 0x06, 0x06, 0x06 -> no commit of 0. Value 1 commits on the 5th sample (counter restarted at the change).
- Digit 1 committed to 7, then 3 samples of 0x49 -> digit_err[1]=1, digit_vld[1]=0, digit_val[7:4] stays 7, upd pulses. Then 3 samples of 0x00 -> err[1]=0, vld[1]=0.
- sample with dig_sel=0000, then 0011 -> sel_err pulses on each, no digit state changes. STABLE_CNT=1 build: a single 0x6F sample on digit 2 -> digit_val[11:8]=9 next cycle.
- Drive rst_n low mid-filter after 2 of 3 samples of 0x66 on digit 0 -> all outputs are 0 immediately (asynchronous). After release, 2 more samples -> no commit; a 3rd -> value 4.
